dense_layer_seq: RTL and testbench

Parametrised, sequential fully-connected layer for the speech-recognition neural network.
- Captures one input vector on a start handshake and runs one input element per cycle through OUT_SIZE parallel MACs.
- Adds the bias exactly once, then applies shift, optional ReLU and saturation.
- Presents a registered output vector with a done pulse, so dense layers and the classifier can be chained by handshake.

---
 rtl/dense_layer_seq_pkg.sv | 69 ++++++
 rtl/dense_layer_seq_weight_rom.sv | 23 ++
 rtl/dense_layer_seq.sv | 107 ++++++++++
 tb/tb_dense_layer_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_layer_seq_pkg.sv
// Shared types, weight/bias tables and helpers for the sequential dense layers.
// Tables are built once at elaboration; LAYER_ID selects a set.
package nn_parameters;

    localparam int N_LAYERS      = 2;
    localparam int LAYER_DEFAULT = 0;
    localparam int LAYER_TEST    = 1;
    localparam int IN_MAX        = 16;
    localparam int OUT_MAX       = 8;
    localparam int PW            = 16;

    localparam int L0_IN_SIZE    = 16;
    localparam int L0_OUT_SIZE   = 8;
    localparam int TEST_IN_SIZE  = 4;
    localparam int TEST_OUT_SIZE = 2;

    typedef logic [N_LAYERS-1:0][IN_MAX-1:0][OUT_MAX-1:0][PW-1:0] weight_tbl_t;
    typedef logic [N_LAYERS-1:0][OUT_MAX-1:0][PW-1:0]             bias_tbl_t;

    typedef enum logic [1:0] {IDLE, LOAD, MAC, POST} state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic weight_tbl_t build_weights();
        weight_tbl_t t;
        int v;
        t = '0;
        for (int i = 0; i < IN_MAX; i++) begin
            for (int j = 0; j < OUT_MAX; j++) begin
                v = ((i * OUT_MAX + j) * 37) % 61 - 30;
                t[LAYER_DEFAULT][i][j] = PW'(v);
            end
        end
        // Test set: column 0 holds +(i+1), column 1 holds -(i+1)
        for (int i = 0; i < TEST_IN_SIZE; i++) begin
            t[LAYER_TEST][i][0] = PW'(i + 1);
            t[LAYER_TEST][i][1] = PW'(-(i + 1));
        end
        return t;
    endfunction

    function automatic bias_tbl_t build_biases();
        bias_tbl_t t;
        t = '0;
        for (int j = 0; j < OUT_MAX; j++) begin
            t[LAYER_DEFAULT][j] = PW'(j * 5 - 17);
        end
        t[LAYER_TEST][0] = PW'(10);
        t[LAYER_TEST][1] = PW'(-10);
        return t;
    endfunction

    localparam weight_tbl_t WEIGHTS = build_weights();
    localparam bias_tbl_t   BIASES  = build_biases();

    // Clamp a signed value into the range of a w-bit two's-complement number.
    function automatic longint saturate(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/dense_layer_seq_weight_rom.sv
// Combinational weight-row / bias lookup for one layer, indexed by input element.
// Zero latency; the row follows i_index in the same cycle.
module dense_weight_rom
    import nn_parameters::*;
#(
    parameter int LAYER_ID = 0,
    parameter int IN_SIZE  = 16,
    parameter int OUT_SIZE = 8,
    parameter int W_W      = 16
) (
    input  logic [idx_w(IN_SIZE)-1:0] i_index,
    output logic signed [W_W-1:0]     o_weight_row [OUT_SIZE],
    output logic signed [W_W-1:0]     o_bias       [OUT_SIZE]
);

    always_comb begin
        for (int j = 0; j < OUT_SIZE; j++) begin
            o_weight_row[j] = W_W'(signed'(WEIGHTS[LAYER_ID][i_index][j]));
            o_bias[j]       = W_W'(signed'(BIASES[LAYER_ID][j]));
        end
    end

endmodule

// File: rtl/dense_layer_seq.sv
// Sequential fully-connected layer: one input element per cycle across OUT_SIZE MAC lanes.
// start in cycle 0 gives done in cycle IN_SIZE+3; start is only accepted while idle.
module dense_layer_seq
    import nn_parameters::*;
#(
    parameter int IN_SIZE    = 16,
    parameter int OUT_SIZE   = 8,
    parameter int IN_W       = 16,
    parameter int IN_SIGNED  = 0,
    parameter int W_W        = 16,
    parameter int ACC_W      = 40,
    parameter int OUT_W      = 32,
    parameter int FRAC_SHIFT = 0,
    parameter int RELU_EN    = 1,
    parameter int LAYER_ID   = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [IN_SIZE-1:0][IN_W-1:0]     input_vector,
    output logic                             busy,
    output logic                             done,
    output logic [OUT_SIZE-1:0][OUT_W-1:0]   output_vector
);

    localparam int IDX_W  = idx_w(IN_SIZE);
    localparam int PROD_W = IN_W + 1 + W_W;

    state_t                       r_state;
    logic [IN_SIZE-1:0][IN_W-1:0] r_in;
    logic [IDX_W-1:0]             r_index;
    logic signed [ACC_W-1:0]      r_acc    [OUT_SIZE];

    logic signed [W_W-1:0]        w_weight_row [OUT_SIZE];
    logic signed [W_W-1:0]        w_bias       [OUT_SIZE];
    logic signed [IN_W:0]         w_in_ext;
    logic signed [PROD_W-1:0]     w_prod   [OUT_SIZE];
    logic signed [ACC_W-1:0]      w_shift  [OUT_SIZE];
    logic signed [OUT_W-1:0]      w_out    [OUT_SIZE];

    dense_weight_rom #(
        .LAYER_ID (LAYER_ID),
        .IN_SIZE  (IN_SIZE),
        .OUT_SIZE (OUT_SIZE),
        .W_W      (W_W)
    ) u_rom (
        .i_index      (r_index),
        .o_weight_row (w_weight_row),
        .o_bias       (w_bias)
    );

    // One extra bit so unsigned inputs stay non-negative in the signed product.
    always_comb begin
        w_in_ext = {1'b0, r_in[r_index]};
        if (IN_SIGNED != 0) w_in_ext[IN_W] = r_in[r_index][IN_W-1];
    end

    always_comb begin
        for (int j = 0; j < OUT_SIZE; j++) begin
            w_prod[j]  = w_in_ext * w_weight_row[j];
            w_shift[j] = r_acc[j] >>> FRAC_SHIFT;
            if ((RELU_EN != 0) && (w_shift[j] < 0)) w_shift[j] = '0;
            w_out[j]   = OUT_W'(saturate(longint'(w_shift[j]), OUT_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            output_vector <= '0;
            r_index       <= '0;
            r_in          <= '0;
            for (int j = 0; j < OUT_SIZE; j++) r_acc[j] <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // busy stays high through the done cycle and on a back-to-back accept
                    busy <= start;
                    if (start) begin
                        r_in    <= input_vector;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    for (int j = 0; j < OUT_SIZE; j++) r_acc[j] <= ACC_W'(w_bias[j]);
                    r_index <= '0;
                    r_state <= MAC;
                end
                MAC: begin
                    for (int j = 0; j < OUT_SIZE; j++) r_acc[j] <= r_acc[j] + ACC_W'(w_prod[j]);
                    r_index <= r_index + 1'b1;
                    if (r_index == IDX_W'(IN_SIZE - 1)) r_state <= POST;
                end
                POST: begin
                    for (int j = 0; j < OUT_SIZE; j++) output_vector[j] <= w_out[j];
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Five parameter variants of the test layer driven in lock-step, each checked
// every cycle against a run-level reference model, plus literal result pins.
module tb_dense_layer_seq;
    import nn_parameters::*;

    localparam int NI = 4;
    localparam int NO = 2;
    localparam int NC = 5;
    localparam int L  = NI + 3;

    // Configurations: A unsigned+ReLU, B signed, C sat8+ReLU, D sat8, E signed+shift1
    int cfg_sgn  [NC] = '{0, 1, 0, 0, 1};
    int cfg_relu [NC] = '{1, 0, 1, 0, 0};
    int cfg_w    [NC] = '{32, 32, 8, 8, 32};
    int cfg_sh   [NC] = '{0, 0, 0, 0, 1};

    int tw [NI][NO] = '{'{1, -1}, '{2, -2}, '{3, -3}, '{4, -4}};
    int tb_b [NO]   = '{10, -10};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 start;
    logic [NI-1:0][15:0]  in_vec;
    logic [NC-1:0]        busy_v;
    logic [NC-1:0]        done_v;
    logic [NO-1:0][31:0]  ov_a, ov_b, ov_e;
    logic [NO-1:0][7:0]   ov_c, ov_d;
    longint               dut_out [NC][NO];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    dense_layer_seq #(.IN_SIZE(NI), .OUT_SIZE(NO), .IN_W(16), .IN_SIGNED(0), .W_W(16), .ACC_W(40),
        .OUT_W(32), .FRAC_SHIFT(0), .RELU_EN(1), .LAYER_ID(LAYER_TEST)) u_a (
        .clk(clk), .rst(rst), .start(start), .input_vector(in_vec),
        .busy(busy_v[0]), .done(done_v[0]), .output_vector(ov_a));
    dense_layer_seq #(.IN_SIZE(NI), .OUT_SIZE(NO), .IN_W(16), .IN_SIGNED(1), .W_W(16), .ACC_W(40),
        .OUT_W(32), .FRAC_SHIFT(0), .RELU_EN(0), .LAYER_ID(LAYER_TEST)) u_b (
        .clk(clk), .rst(rst), .start(start), .input_vector(in_vec),
        .busy(busy_v[1]), .done(done_v[1]), .output_vector(ov_b));
    dense_layer_seq #(.IN_SIZE(NI), .OUT_SIZE(NO), .IN_W(16), .IN_SIGNED(0), .W_W(16), .ACC_W(40),
        .OUT_W(8), .FRAC_SHIFT(0), .RELU_EN(1), .LAYER_ID(LAYER_TEST)) u_c (
        .clk(clk), .rst(rst), .start(start), .input_vector(in_vec),
        .busy(busy_v[2]), .done(done_v[2]), .output_vector(ov_c));
    dense_layer_seq #(.IN_SIZE(NI), .OUT_SIZE(NO), .IN_W(16), .IN_SIGNED(0), .W_W(16), .ACC_W(40),
        .OUT_W(8), .FRAC_SHIFT(0), .RELU_EN(0), .LAYER_ID(LAYER_TEST)) u_d (
        .clk(clk), .rst(rst), .start(start), .input_vector(in_vec),
        .busy(busy_v[3]), .done(done_v[3]), .output_vector(ov_d));
    dense_layer_seq #(.IN_SIZE(NI), .OUT_SIZE(NO), .IN_W(16), .IN_SIGNED(1), .W_W(16), .ACC_W(40),
        .OUT_W(32), .FRAC_SHIFT(1), .RELU_EN(0), .LAYER_ID(LAYER_TEST)) u_e (
        .clk(clk), .rst(rst), .start(start), .input_vector(in_vec),
        .busy(busy_v[4]), .done(done_v[4]), .output_vector(ov_e));

    always_comb begin
        for (int j = 0; j < NO; j++) begin
            dut_out[0][j] = longint'(signed'(ov_a[j]));
            dut_out[1][j] = longint'(signed'(ov_b[j]));
            dut_out[2][j] = longint'(signed'(ov_c[j]));
            dut_out[3][j] = longint'(signed'(ov_d[j]));
            dut_out[4][j] = longint'(signed'(ov_e[j]));
        end
    end

    task automatic chk(input string name, input int c, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s cfg%0d actual=%0d required=%0d at %0t", name, c, act, exp, $time);
        end
    endtask

    // Expected neuron output straight from the layer definition.
    function automatic longint model_y(input int c, input logic [NI-1:0][15:0] v, input int j);
        longint acc;
        longint x;
        longint hi;
        longint lo;
        acc = tb_b[j];
        for (int i = 0; i < NI; i++) begin
            x = (cfg_sgn[c] != 0) ? longint'(signed'(v[i])) : longint'(v[i]);
            acc += x * tw[i][j];
        end
        acc = acc >>> cfg_sh[c];
        if (cfg_relu[c] != 0 && acc < 0) acc = 0;
        hi = (longint'(1) <<< (cfg_w[c] - 1)) - 1;
        lo = -hi - 1;
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
        return acc;
    endfunction

    // Run-level model: m_n = cycles since the accepted start (0 = idle).
    int                  m_n = 0;
    logic [NI-1:0][15:0] m_cap;
    longint              m_out [NC][NO];

    always @(posedge clk) begin : model
        bit accept;
        if (rst) begin
            m_n = 0;
            for (int c = 0; c < NC; c++) for (int j = 0; j < NO; j++) m_out[c][j] = 0;
        end else begin
            accept = ((m_n == 0) || (m_n == L)) && start;
            if (m_n == L - 1)
                for (int c = 0; c < NC; c++) for (int j = 0; j < NO; j++) m_out[c][j] = model_y(c, m_cap, j);
            if (accept) begin
                m_cap = in_vec;
                m_n   = 1;
            end else if (m_n == L) m_n = 0;
            else if (m_n > 0) m_n++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < NC; c++) begin
                chk("busy", c, longint'(busy_v[c]), longint'(m_n != 0));
                chk("done", c, longint'(done_v[c]), longint'(m_n == L));
                for (int j = 0; j < NO; j++) chk("out", c, dut_out[c][j], m_out[c][j]);
            end
        end
    end

    function automatic logic [NI-1:0][15:0] mk(input logic [15:0] a, input logic [15:0] b,
                                               input logic [15:0] c, input logic [15:0] d);
        logic [NI-1:0][15:0] v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    // Pulse start with v and stop at the negedge of the done cycle.
    task automatic run_one(input logic [NI-1:0][15:0] v);
        int k;
        in_vec = v;
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        k = 0;
        while (k < 20 && !done_v[0]) begin
            cyc();
            k++;
        end
        chk("latency", 0, k, L - 1);
    endtask

    task automatic pin(input string name, input int c, input longint e0, input longint e1);
        chk(name, c, dut_out[c][0], e0);
        chk(name, c, dut_out[c][1], e1);
    endtask

    initial begin
        int dn;
        rst = 1'b1; start = 1'b0; in_vec = '0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_busy", 0, longint'(busy_v[0]), 0);
        pin("rst_out", 0, 0, 0);

        run_one(mk(1, 1, 1, 1));
        pin("relu_basic", 0, 20, 0);
        pin("signed_basic", 1, 20, -20);
        pin("shift_pos", 4, 10, -10);
        cyc();
        chk("busy_after", 0, longint'(busy_v[0]), 0);

        run_one(mk(16'hFFFF, 0, 0, 0));
        pin("signed_neg1", 1, 9, -9);
        pin("unsigned_ffff", 0, 65545, 0);
        pin("sat_relu_ffff", 2, 127, 0);
        cyc();

        run_one(mk(100, 100, 100, 100));
        pin("sat_relu", 2, 127, 0);
        pin("sat_norelu", 3, 127, -128);
        cyc();

        run_one(mk(16'hFFFD, 0, 0, 0));
        pin("shift_floor", 4, 3, -4);
        cyc();
        run_one(mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
        pin("shift_zero", 4, 0, 0);
        cyc();

        // start held high: a result every L cycles
        in_vec = mk(1, 1, 1, 1);
        start  = 1'b1;
        dn = 0;
        for (int i = 1; i <= 3 * L; i++) begin
            cyc();
            if (done_v[0]) begin
                dn++;
                pin("held_start", 0, 20, 0);
            end
        end
        start = 1'b0;
        chk("held_done_count", 0, dn, 3);
        repeat (L + 1) cyc();

        // input changes and extra starts during busy are ignored
        in_vec = mk(1, 1, 1, 1);
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        cyc();
        in_vec = mk(7, 7, 7, 7);
        cyc();
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        dn = 0;
        for (int i = 0; i < 2 * L; i++) begin
            if (done_v[0]) begin
                dn++;
                pin("ignore_change", 0, 20, 0);
            end
            cyc();
        end
        chk("ignore_done_count", 0, dn, 1);

        // reset in cycle 3 of a run aborts it
        in_vec = mk(2, 2, 2, 2);
        start  = 1'b1;
        cyc();
        start  = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_busy", 0, longint'(busy_v[0]), 0);
        chk("midrst_done", 0, longint'(done_v[0]), 0);
        pin("midrst_out", 0, 0, 0);
        run_one(mk(1, 1, 1, 1));
        pin("after_rst", 0, 20, 0);
        pin("after_rst_b", 1, 20, -20);

        // randomized traffic, including sporadic resets and idle gaps
        for (int i = 0; i < 400; i++) begin
            cyc();
            start = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 80) == 0);
            for (int e = 0; e < NI; e++) begin
                case ($urandom_range(0, 2))
                    0:       in_vec[e] = 16'($urandom);
                    1:       in_vec[e] = 16'($urandom_range(0, 9));
                    default: in_vec[e] = 16'(-$urandom_range(0, 9));
                endcase
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (L + 2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
